// File: rtl/game_flow_ctrl.sv
// Game flow controller: screen sequencing (title/player/setup/chess) and the
// in-game move-entry FSM with cursor, piece selection and validator handshake.
`timescale 1ns/1ps

package common_enums;
  typedef enum logic [1:0] {
    TITLE  = 2'd0,
    PLAYER = 2'd1,
    SETUP  = 2'd2,
    CHESS  = 2'd3
  } screen_state_t;

  typedef enum logic [1:0] {
    PLAYER_SEL = 2'd0,
    PIECE_SEL  = 2'd1,
    POS_SEL    = 2'd2,
    MOVE_VAL   = 2'd3
  } move_state_t;
endpackage

module game_flow_ctrl
  import common_enums::*;
#(
  parameter int COORD_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_start,
  input  logic                   key_sel,
  input  logic                   key_back,
  input  logic                   key_up,
  input  logic                   key_down,
  input  logic                   key_left,
  input  logic                   key_right,
  input  logic                   setup_done,
  input  logic                   own_piece,
  input  logic                   game_over,
  output logic                   mv_valid,
  input  logic                   mv_ready,
  output logic [2*COORD_W-1:0]   mv_from,
  output logic [2*COORD_W-1:0]   mv_to,
  input  logic                   mv_resp,
  input  logic                   mv_ok,
  output screen_state_t          screen_state,
  output move_state_t            move_state,
  output logic                   player,
  output logic [2*COORD_W-1:0]   cursor,
  output logic [2*COORD_W-1:0]   sel_sq
);

  localparam int SQ_W = 2 * COORD_W;
  localparam logic [COORD_W-1:0] COORD_MAX  = {COORD_W{1'b1}};
  localparam logic [COORD_W-1:0] COORD_ZERO = {COORD_W{1'b0}};
  localparam logic [SQ_W-1:0]    SQ_ZERO    = {SQ_W{1'b0}};
  localparam logic [SQ_W-1:0]    START_SQ   = {COORD_W'(1), COORD_W'(4)};

  // Saturating one-step move; opposite pulses cancel out.
  function automatic logic [COORD_W-1:0] step_coord(
    input logic [COORD_W-1:0] c,
    input logic               inc,
    input logic               dec
  );
    logic [COORD_W-1:0] r;
    if (inc && !dec && (c != COORD_MAX)) begin
      r = c + COORD_W'(1);
    end else if (dec && !inc && (c != COORD_ZERO)) begin
      r = c - COORD_W'(1);
    end else begin
      r = c;
    end
    return r;
  endfunction

  screen_state_t      screen_nxt;
  move_state_t        move_nxt;
  logic               player_nxt;
  logic [SQ_W-1:0]    cursor_nxt;
  logic [SQ_W-1:0]    sel_sq_nxt;
  logic               mv_valid_nxt;
  logic [SQ_W-1:0]    mv_from_nxt;
  logic [SQ_W-1:0]    mv_to_nxt;
  logic               resp_wait;
  logic               resp_wait_nxt;
  logic [SQ_W-1:0]    moved_cursor;

  // Next-state logic for screen and move FSMs plus all registered outputs.
  always_comb begin
    screen_nxt    = screen_state;
    move_nxt      = move_state;
    player_nxt    = player;
    cursor_nxt    = cursor;
    sel_sq_nxt    = sel_sq;
    mv_valid_nxt  = mv_valid;
    mv_from_nxt   = mv_from;
    mv_to_nxt     = mv_to;
    resp_wait_nxt = resp_wait;
    moved_cursor  = {step_coord(cursor[SQ_W-1:COORD_W], key_up, key_down),
                     step_coord(cursor[COORD_W-1:0], key_right, key_left)};

    case (screen_state)
      TITLE: begin
        move_nxt      = PLAYER_SEL;
        mv_valid_nxt  = 1'b0;
        resp_wait_nxt = 1'b0;
        if (key_start) begin
          screen_nxt = PLAYER;
        end else begin
          screen_nxt = TITLE;
        end
      end
      PLAYER: begin
        move_nxt      = PLAYER_SEL;
        mv_valid_nxt  = 1'b0;
        resp_wait_nxt = 1'b0;
        if (key_sel) begin
          screen_nxt = SETUP;
        end else begin
          screen_nxt = PLAYER;
        end
      end
      SETUP: begin
        move_nxt      = PLAYER_SEL;
        mv_valid_nxt  = 1'b0;
        resp_wait_nxt = 1'b0;
        if (setup_done) begin
          screen_nxt = CHESS;
          player_nxt = 1'b0;
          cursor_nxt = START_SQ;
          sel_sq_nxt = SQ_ZERO;
        end else begin
          screen_nxt = SETUP;
        end
      end
      CHESS: begin
        // game_over aborts everything, including an in-flight request.
        if (game_over) begin
          screen_nxt    = TITLE;
          move_nxt      = PLAYER_SEL;
          mv_valid_nxt  = 1'b0;
          resp_wait_nxt = 1'b0;
        end else begin
          case (move_state)
            PLAYER_SEL: begin
              move_nxt = PIECE_SEL;
            end
            PIECE_SEL: begin
              cursor_nxt = moved_cursor;
              if (key_sel && own_piece) begin
                sel_sq_nxt = cursor;
                move_nxt   = POS_SEL;
              end else begin
                move_nxt   = PIECE_SEL;
              end
            end
            POS_SEL: begin
              cursor_nxt = moved_cursor;
              if (key_back) begin
                move_nxt = PIECE_SEL;
              end else if (key_sel && (cursor == sel_sq)) begin
                move_nxt = PIECE_SEL;
              end else if (key_sel) begin
                mv_from_nxt   = sel_sq;
                mv_to_nxt     = cursor;
                mv_valid_nxt  = 1'b1;
                resp_wait_nxt = 1'b0;
                move_nxt      = MOVE_VAL;
              end else begin
                move_nxt = POS_SEL;
              end
            end
            MOVE_VAL: begin
              // A verdict counts only once the request has been accepted.
              if (mv_valid && mv_ready) begin
                mv_valid_nxt  = 1'b0;
                resp_wait_nxt = 1'b1;
              end else if (resp_wait && mv_resp) begin
                resp_wait_nxt = 1'b0;
                if (mv_ok) begin
                  player_nxt = ~player;
                  move_nxt   = PLAYER_SEL;
                end else begin
                  move_nxt   = PIECE_SEL;
                end
              end else begin
                move_nxt = MOVE_VAL;
              end
            end
            default: begin
              move_nxt      = PLAYER_SEL;
              mv_valid_nxt  = 1'b0;
              resp_wait_nxt = 1'b0;
            end
          endcase
        end
      end
      default: begin
        screen_nxt    = TITLE;
        move_nxt      = PLAYER_SEL;
        mv_valid_nxt  = 1'b0;
        resp_wait_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      screen_state <= TITLE;
      move_state   <= PLAYER_SEL;
      player       <= 1'b0;
      cursor       <= SQ_ZERO;
      sel_sq       <= SQ_ZERO;
      mv_valid     <= 1'b0;
      mv_from      <= SQ_ZERO;
      mv_to        <= SQ_ZERO;
      resp_wait    <= 1'b0;
    end else begin
      screen_state <= screen_nxt;
      move_state   <= move_nxt;
      player       <= player_nxt;
      cursor       <= cursor_nxt;
      sel_sq       <= sel_sq_nxt;
      mv_valid     <= mv_valid_nxt;
      mv_from      <= mv_from_nxt;
      mv_to        <= mv_to_nxt;
      resp_wait    <= resp_wait_nxt;
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: a behavioural model predicts each cycle's
// outputs and every accepted move request; monitors pop and compare.
`timescale 1ns/1ps

module tb_game_flow_ctrl;
  import common_enums::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_start, key_sel, key_back, key_up, key_down, key_left, key_right;
  logic setup_done, own_piece, game_over, mv_ready, mv_resp, mv_ok;
  logic mv_valid, player;
  logic [5:0] mv_from, mv_to, cursor, sel_sq;
  screen_state_t screen_state;
  move_state_t   move_state;

  localparam logic [12:0] K_START = 13'h0001, K_SEL   = 13'h0002, K_BACK  = 13'h0004;
  localparam logic [12:0] K_UP    = 13'h0008, K_DOWN  = 13'h0010, K_LEFT  = 13'h0020;
  localparam logic [12:0] K_RIGHT = 13'h0040, K_SETUP = 13'h0080, K_OWN   = 13'h0100;
  localparam logic [12:0] K_GOVER = 13'h0200, K_READY = 13'h0400, K_RESP  = 13'h0800;
  localparam logic [12:0] K_OK    = 13'h1000;

  typedef struct packed {
    screen_state_t scr;
    move_state_t   mst;
    logic          ply;
    logic [5:0]    cur;
    logic [5:0]    sel;
    logic          valid;
    logic [5:0]    from;
    logic [5:0]    to;
  } snap_t;

  typedef struct packed {
    logic [5:0] from;
    logic [5:0] to;
  } req_t;

  snap_t exp_q[$];
  req_t  req_q[$];
  int checks = 0;
  int errors = 0;

  screen_state_t m_scr;
  move_state_t   m_mst;
  logic          m_ply, m_valid, m_wait;
  int            m_row, m_col, m_srow, m_scol;
  logic [5:0]    m_from, m_to;

  game_flow_ctrl #(.COORD_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_start(key_start), .key_sel(key_sel), .key_back(key_back),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .setup_done(setup_done), .own_piece(own_piece), .game_over(game_over),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_from(mv_from), .mv_to(mv_to),
    .mv_resp(mv_resp), .mv_ok(mv_ok),
    .screen_state(screen_state), .move_state(move_state), .player(player),
    .cursor(cursor), .sel_sq(sel_sq)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] sq(input int r, input int c);
    return 6'(r * 8 + c);
  endfunction

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > 7) return 7;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    m_scr = TITLE; m_mst = PLAYER_SEL; m_ply = 1'b0; m_valid = 1'b0; m_wait = 1'b0;
    m_row = 0; m_col = 0; m_srow = 0; m_scol = 0; m_from = 6'd0; m_to = 6'd0;
  endtask

  // Predict the state after the coming clock edge from the game rules.
  task automatic model_step(input logic [12:0] k);
    int nr, nc;
    snap_t s;
    req_t r;
    if (m_valid && k[10]) begin
      r.from = m_from; r.to = m_to;
      req_q.push_back(r);
    end
    nr = sat(m_row + int'(k[3]) - int'(k[4]));
    nc = sat(m_col + int'(k[6]) - int'(k[5]));
    case (m_scr)
      TITLE:  if (k[0]) m_scr = PLAYER;
      PLAYER: if (k[1]) m_scr = SETUP;
      SETUP:  if (k[7]) begin
        m_scr = CHESS; m_mst = PLAYER_SEL; m_ply = 1'b0;
        m_row = 1; m_col = 4; m_srow = 0; m_scol = 0;
      end
      default: begin
        if (k[9]) begin
          m_scr = TITLE; m_mst = PLAYER_SEL; m_valid = 1'b0; m_wait = 1'b0;
        end else begin
          case (m_mst)
            PLAYER_SEL: m_mst = PIECE_SEL;
            PIECE_SEL: begin
              if (k[1] && k[8]) begin
                m_srow = m_row; m_scol = m_col; m_mst = POS_SEL;
              end
              m_row = nr; m_col = nc;
            end
            POS_SEL: begin
              if (k[2]) m_mst = PIECE_SEL;
              else if (k[1]) begin
                if (m_row == m_srow && m_col == m_scol) m_mst = PIECE_SEL;
                else begin
                  m_from = sq(m_srow, m_scol); m_to = sq(m_row, m_col);
                  m_valid = 1'b1; m_mst = MOVE_VAL;
                end
              end
              m_row = nr; m_col = nc;
            end
            default: begin
              if (m_wait && k[11]) begin
                m_wait = 1'b0;
                m_ply = k[12] ? ~m_ply : m_ply;
                m_mst = k[12] ? PLAYER_SEL : PIECE_SEL;
              end else if (m_valid && k[10]) begin
                m_valid = 1'b0; m_wait = 1'b1;
              end
            end
          endcase
        end
      end
    endcase
    s.scr = m_scr; s.mst = m_mst; s.ply = m_ply; s.cur = sq(m_row, m_col);
    s.sel = sq(m_srow, m_scol); s.valid = m_valid; s.from = m_from; s.to = m_to;
    exp_q.push_back(s);
  endtask

  task automatic drive(input logic [12:0] k);
    key_start = k[0]; key_sel = k[1]; key_back = k[2]; key_up = k[3];
    key_down = k[4]; key_left = k[5]; key_right = k[6]; setup_done = k[7];
    own_piece = k[8]; game_over = k[9]; mv_ready = k[10]; mv_resp = k[11];
    mv_ok = k[12];
  endtask

  task automatic go(input logic [12:0] k);
    @(negedge clk); #1;
    drive(k);
    model_step(k);
  endtask

  task automatic check_reset();
    cmp("rst_screen", 8'(screen_state), 8'(TITLE));
    cmp("rst_move", 8'(move_state), 8'(PLAYER_SEL));
    cmp("rst_player", 8'(player), 8'd0);
    cmp("rst_cursor", 8'(cursor), 8'd0);
    cmp("rst_sel_sq", 8'(sel_sq), 8'd0);
    cmp("rst_mv_valid", 8'(mv_valid), 8'd0);
    cmp("rst_mv_from", 8'(mv_from), 8'd0);
    cmp("rst_mv_to", 8'(mv_to), 8'd0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk); #1;
    drive(13'd0);
    rst_n = 1'b0;
    #1;
    check_reset();
    model_reset();
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [12:0] rand_keys();
    logic [12:0] k;
    k[0]  = ($urandom_range(3) == 0);
    k[1]  = ($urandom_range(2) == 0);
    k[2]  = ($urandom_range(5) == 0);
    k[3]  = ($urandom_range(3) == 0);
    k[4]  = ($urandom_range(3) == 0);
    k[5]  = ($urandom_range(3) == 0);
    k[6]  = ($urandom_range(3) == 0);
    k[7]  = ($urandom_range(2) == 0);
    k[8]  = 1'($urandom_range(1));
    k[9]  = ($urandom_range(60) == 0);
    k[10] = 1'($urandom_range(1));
    k[11] = ($urandom_range(2) == 0);
    k[12] = 1'($urandom_range(1));
    return k;
  endfunction

  // Per-cycle output monitor.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp("screen_state", 8'(screen_state), 8'(e.scr));
        cmp("move_state", 8'(move_state), 8'(e.mst));
        cmp("player", 8'(player), 8'(e.ply));
        cmp("cursor", 8'(cursor), 8'(e.cur));
        cmp("sel_sq", 8'(sel_sq), 8'(e.sel));
        cmp("mv_valid", 8'(mv_valid), 8'(e.valid));
        cmp("mv_from", 8'(mv_from), 8'(e.from));
        cmp("mv_to", 8'(mv_to), 8'(e.to));
      end
    end
  end

  // Accepted move-request monitor, sampled mid-cycle before the active edge.
  initial begin
    req_t r;
    forever begin
      @(negedge clk); #3;
      if (rst_n && mv_valid && mv_ready) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL handshake at %0t: got request %0o->%0o expected none", $time, mv_from, mv_to);
        end else begin
          r = req_q.pop_front();
          cmp("hs_from", 8'(mv_from), 8'(r.from));
          cmp("hs_to", 8'(mv_to), 8'(r.to));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(13'd0);
    rst_n = 1'b0;
    #3;
    check_reset();
    model_reset();
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Screen sequence into CHESS, then PLAYER_SEL for one cycle.
    go(K_START); go(K_SEL); go(K_SETUP); go(13'd0);
    // Select 14, move up twice, request 14->34 with a slow validator.
    go(K_SEL | K_OWN); go(K_UP); go(K_UP); go(K_SEL);
    go(13'd0); go(13'd0); go(13'd0); go(K_READY);
    go(K_RESP | K_OK); go(13'd0);
    // back beats sel, early verdict ignored, rejected move.
    go(K_SEL | K_OWN); go(K_BACK | K_SEL); go(K_SEL | K_OWN); go(K_RIGHT);
    go(K_SEL); go(K_RESP | K_OK); go(K_READY); go(K_RESP);
    // Deselect and latch with a simultaneous cursor move.
    go(K_SEL | K_OWN); go(K_SEL); go(K_SEL | K_OWN | K_UP);
    // Drive to row7,col0 then probe saturation and opposite pulses.
    repeat (8) go(K_UP | K_LEFT);
    go(K_UP | K_LEFT); go(K_UP | K_DOWN | K_RIGHT); go(K_BACK);
    // game_over while a request is pending.
    go(K_SEL | K_OWN); go(K_DOWN); go(K_SEL); go(13'd0);
    go(K_GOVER); go(K_READY | K_RESP | K_OK); go(K_RESP);
    // Reset mid-request.
    go(K_START); go(K_SEL); go(K_SETUP); go(13'd0);
    go(K_SEL | K_OWN); go(K_RIGHT); go(K_SEL); go(13'd0);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) do_reset();
      else go(rand_keys());
    end
    go(13'd0); go(13'd0);
    @(negedge clk); #4;
    checks++;
    if (exp_q.size() != 0 || req_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", exp_q.size(), req_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
